// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Operation codes, FSM states and counter sizing.
package mdu_pkg;

  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MTHI  = 4'd4,
    MTLO  = 4'd5,
    MFHI  = 4'd6,
    MFLO  = 4'd7,
    MADD  = 4'd8,
    MADDU = 4'd9,
    MSUB  = 4'd10,
    MSUBU = 4'd11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

  function automatic int cnt_width(int m, int d);
    int mx;
    mx = (m > d) ? m : d;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the execute stage and the MDU.
// master drives operations, slave is the unit itself.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       mdu_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_result;

  modport master (
    output start, mdu_op, src_a, src_b,
    input  busy, hi, lo, mf_result
  );

  modport slave (
    input  start, mdu_op, src_a, src_b,
    output busy, hi, lo, mf_result
  );
endinterface

// File: rtl/mdu_div.sv
// Combinational signed/unsigned divider with zero-divisor
// detection; quotient truncates toward zero.
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             zero
);
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] ua;
  logic [WIDTH-1:0] ub;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  // most-negative / -1 falls out naturally: magnitude wraps back
  always_comb begin
    zero  = (b == '0);
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    ua    = neg_a ? -a : a;
    ub    = zero ? WIDTH'(1) : (neg_b ? -b : b);
    uq    = ua / ub;
    ur    = ua % ub;
    quo   = (neg_a ^ neg_b) ? -uq : uq;
    rem   = neg_a ? -ur : ur;
  end
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);
  localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_wr;

  logic             sgn;
  logic             is_mul;
  logic             is_div;
  logic             is_mthi;
  logic             is_mtlo;
  logic [W2-1:0]    ea;
  logic [W2-1:0]    eb;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    mul_res;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             dz;

  always_comb begin
    sgn     = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (bus.mdu_op)
      MULT:    begin is_mul = 1'b1; sgn = 1'b1; end
      MULTU:   is_mul = 1'b1;
      DIV:     begin is_div = 1'b1; sgn = 1'b1; end
      DIVU:    is_div = 1'b1;
      MTHI:    is_mthi = 1'b1;
      MTLO:    is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      MADD:    begin is_mul = 1'b1; sgn = 1'b1; end
      MADDU:   is_mul = 1'b1;
      MSUB:    begin is_mul = 1'b1; sgn = 1'b1; end
      MSUBU:   is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  // extend to 2*WIDTH so one multiplier serves both signednesses
  always_comb begin
    ea = sgn ? {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a}
             : {{WIDTH{1'b0}}, bus.src_a};
    eb = sgn ? {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b}
             : {{WIDTH{1'b0}}, bus.src_b};
    prod = ea * eb;
  end

`ifdef MDU_MADD_EN
  always_comb begin
    unique case (bus.mdu_op)
      MADD, MADDU: mul_res = {hi_q, lo_q} + prod;
      MSUB, MSUBU: mul_res = {hi_q, lo_q} - prod;
      default:     mul_res = prod;
    endcase
  end
`else
  assign mul_res = prod;
`endif

  mdu_div #(.WIDTH(WIDTH)) u_div (
    .a    (bus.src_a),
    .b    (bus.src_b),
    .sgn  (sgn),
    .quo  (quo),
    .rem  (rem),
    .zero (dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            unique case (1'b1)
              is_mul: begin
                state   <= S_MUL;
                busy_q  <= 1'b1;
                cnt     <= CW'(MULT_CYCLES);
                pend_hi <= mul_res[W2-1:WIDTH];
                pend_lo <= mul_res[WIDTH-1:0];
                pend_wr <= 1'b1;
              end
              is_div: begin
                state   <= S_DIV;
                busy_q  <= 1'b1;
                cnt     <= CW'(DIV_CYCLES);
                pend_hi <= rem;
                pend_lo <= quo;
                pend_wr <= ~dz;
              end
              is_mthi: hi_q <= bus.src_a;
              is_mtlo: lo_q <= bus.src_a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (cnt == CW'(1)) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.mf_result =
    (bus.mdu_op == MFHI) ? hi_q :
    (bus.mdu_op == MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit (default 32-bit,
// 5/10 cycle latencies); define MDU_MADD_EN for the MAC vectors.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the issue edge
  task automatic drive(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.src_a  = a;
    bus.src_b  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.mdu_op = MFHI;
    bus.src_a  = '0;
    bus.src_b  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);

    drive(MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("mult_cyc", n, 32'd5);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

    drive(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);

    drive(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cyc", n, 32'd10);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    drive(DIVU, 32'd7, 32'd0);
    wait_idle(n);
    chk("dz_cyc", n, 32'd10);
    chk("dz_hi", bus.hi, 32'hFFFF_FFFF);
    chk("dz_lo", bus.lo, 32'hFFFF_FFFD);

    drive(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'h0);

    drive(DIVU, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    // stalled MTLO and operand changes while busy
    drive(MULTU, 32'h0001_0000, 32'h0001_0001);
    bus.mdu_op = MFLO;
    bus.src_a  = 32'h5555_5555;
    bus.src_b  = 32'hAAAA_AAAA;
    #1 chk("mf_busy", bus.mf_result, 32'd14);
    @(negedge clk);
    drive(MTLO, 32'h1234, 32'h0);
    wait_idle(n);
    chk("stall_cyc", n, 32'd3);
    chk("stall_hi", bus.hi, 32'h0000_0001);
    chk("stall_lo", bus.lo, 32'h0001_0000);

    drive(MTHI, 32'hDEAD_BEEF, 32'h0);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    bus.mdu_op = MFHI;
    #1 chk("mfhi", bus.mf_result, 32'hDEAD_BEEF);
    bus.mdu_op = DIV;
    #1 chk("mf_other", bus.mf_result, 32'h0);
    @(negedge clk);
    chk("mthi_busy2", {31'd0, bus.busy}, 32'd0);

    // reset mid-divide, with a start that must be dropped
    drive(DIV, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.mdu_op = MTHI;
    bus.src_a  = 32'h55;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_hi", bus.hi, 32'h0);
    chk("mid_lo", bus.lo, 32'h0);
    repeat (12) @(negedge clk);
    chk("late_hi", bus.hi, 32'h0);
    chk("late_lo", bus.lo, 32'h0);

    drive(MTLO, 32'hFFFF_FFFF, 32'h0);
    drive(MADDU, 32'd1, 32'd1);
    wait_idle(n);
`ifdef MDU_MADD_EN
    chk("madd_cyc", n, 32'd5);
    chk("madd_hi", bus.hi, 32'd1);
    chk("madd_lo", bus.lo, 32'd0);
`else
    chk("madd_cyc", n, 32'd0);
    chk("madd_hi", bus.hi, 32'd0);
    chk("madd_lo", bus.lo, 32'hFFFF_FFFF);
`endif
    drive(MSUB, 32'd1, 32'd1);
    wait_idle(n);
    chk("msub_hi", bus.hi, 32'd0);
    chk("msub_lo", bus.lo, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 Parameter MULT_CYCLES, default 5, busy cycles for multiply ops (>=1).
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for divide ops (>=1).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  issue mdu_op this cycle.
REQ-007 mdu_op  input  4  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO (codes in package).
REQ-008 src_a  input  WIDTH  rs operand.
REQ-009 src_b  input  WIDTH  rt operand.
REQ-010 busy  output  1  multi-cycle operation in flight.
REQ-011 hi  output  WIDTH  architectural HI register.
REQ-012 lo  output  WIDTH  architectural LO register.
REQ-013 mf_result  output  WIDTH  combinational: hi when mdu_op=MFHI, lo when MFLO, else 0.

Function
REQ-014 FSM states: IDLE, MUL, DIV; busy=1 exactly in MUL and DIV.
REQ-015 IDLE + start + MULT/MULTU: latch product, load counter with MULT_CYCLES, enter MUL next edge.
REQ-016 IDLE + start + DIV/DIVU: latch quotient/remainder, load counter with DIV_CYCLES, enter DIV next edge.
REQ-017 Counter decrements each cycle in MUL/DIV; at count 1 HI/LO commit and FSM returns IDLE on the same edge busy falls.
REQ-018 Issue at edge T gives busy high for exactly MULT_CYCLES (or DIV_CYCLES) cycles; new HI/LO visible the cycle busy is low.
REQ-019 MULT: {hi,lo} = signed 2*WIDTH product; MULTU unsigned.
REQ-020 DIV: lo = signed quotient truncated toward zero, hi = remainder with dividend's sign; DIVU unsigned.
REQ-021 Divisor zero: DIV/DIVU still run full DIV_CYCLES; hi and lo unchanged on commit.
REQ-022 Signed DIV of most-negative by -1: lo = most-negative value, hi = 0.
REQ-023 MTHI/MTLO with start in IDLE: write src_a to hi/lo at next edge, busy stays 0.
REQ-024 Any start while busy=1 is ignored; operands not latched, HI/LO unaffected (pipeline stalls upstream).
REQ-025 MFHI/MFLO never change state; mf_result while busy reflects pre-operation values.
REQ-026 Operands latched at issue; src_a/src_b changes during busy have no effect.

Reset
REQ-027 reset at edge: state IDLE, counter 0, busy 0, hi 0, lo 0, overriding any in-flight op (no commit).
REQ-028 start coincident with reset is dropped.

Configuration
REQ-029 Macro MDU_MADD_EN defined: adds MADD, MADDU, MSUB, MSUBU; {hi,lo} +/- signed or unsigned product, wrap modulo 2^(2*WIDTH), MULT_CYCLES latency.
REQ-030 MDU_MADD_EN undefined: those codes treated as no-op, busy stays 0, HI/LO unchanged.

Structure
REQ-031 Package mdu_pkg holds mdu_op encodings, FSM state enum, and counter-width derivation from max(MULT_CYCLES, DIV_CYCLES).
REQ-032 Sub-module mdu_div (combinational signed/unsigned divide with zero and overflow handling) is natural; multiply stays inline.

Verification
REQ-033 MULT a=0xFFFFFFFE, b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 DIV a=-7, b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged after 10 cycles.
REQ-035 MULTU issued, second start MTLO 0x1234 at cycle 2 of busy -> ignored, lo = product low word.
REQ-036 DIV issued, reset at cycle 4 -> next cycle busy=0, hi=lo=0, no later commit.
REQ-037 MTHI 0xDEADBEEF then MFHI next cycle -> mf_result=0xDEADBEEF, busy never asserted.
REQ-038 With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0; without macro -> unchanged.
